// File: rtl/uart_mem_sequencer.sv
// Buffers a UART frame into memory, starts the downsampler, then streams the buffer back out; UART_SEQ_CHECKSUM_EN appends an XOR byte.
// Latency: memory write one cycle after an rx_byte_done rising edge; a tx byte is loaded two cycles after its address is presented.
// Backpressure: holds in TX_LOAD while tx_busy is high and waits for each byte's busy rise and fall before fetching the next.
module uart_mem_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              rx_byte_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_wr_en,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, RX, PROC, TX_RD, TX_LOAD, TX_WAIT, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q, cnt, cnt_inc;
    logic              rx_done_d, rx_edge, last_byte, seen_busy;
    logic              we_nxt, wr_nxt, ps_nxt, done_nxt;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_phase;
`endif

    // One extra counter bit lets len=0 mean a full 2^ADDR_W-byte frame.
    assign cnt_inc   = cnt + (ADDR_W+1)'(1);
    assign last_byte = (cnt_inc == len_q);
    assign rx_edge   = rx_byte_done & ~rx_done_d;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_50m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        ps_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RX;
            RX: begin
                if (mem_we && last_byte) begin
                    state_nxt = PROC;
                    ps_nxt    = 1'b1;
                end else if (rx_edge) begin
                    we_nxt = 1'b1;
                end
            end
            PROC:    if (proc_done) state_nxt = TX_RD;
            TX_RD:   state_nxt = TX_LOAD;
            TX_LOAD: begin
                if (!tx_busy) begin
                    wr_nxt    = 1'b1;
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (seen_busy && !tx_busy) begin
`ifdef UART_SEQ_CHECKSUM_EN
                    if (csum_phase) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (last_byte) begin
                        state_nxt = TX_LOAD;
                    end else begin
                        state_nxt = TX_RD;
                    end
`else
                    if (last_byte) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = TX_RD;
                    end
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            len_q      <= '0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            tx_wr_en   <= 1'b0;
            tx_data    <= '0;
            proc_start <= 1'b0;
            done       <= 1'b0;
            rx_done_d  <= 1'b0;
            seen_busy  <= 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            rx_done_d  <= rx_byte_done;
            mem_we     <= we_nxt;
            tx_wr_en   <= wr_nxt;
            proc_start <= ps_nxt;
            done       <= done_nxt;
            if (we_nxt) mem_wdata <= rx_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= {(len == '0), len};
                        cnt      <= '0;
                        mem_addr <= '0;
`ifdef UART_SEQ_CHECKSUM_EN
                        csum       <= '0;
                        csum_phase <= 1'b0;
`endif
                    end
                end
                RX: begin
                    if (mem_we) begin
                        if (last_byte) begin
                            mem_addr <= '0;
                            cnt      <= '0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            cnt      <= cnt_inc;
                        end
                    end
                end
                TX_LOAD: begin
                    if (!tx_busy) begin
                        seen_busy <= 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
                        tx_data <= csum_phase ? csum : mem_rdata;
                        if (!csum_phase) csum <= csum ^ mem_rdata;
`else
                        tx_data <= mem_rdata;
`endif
                    end
                end
                TX_WAIT: begin
                    if (tx_busy) seen_busy <= 1'b1;
                    if (seen_busy && !tx_busy) begin
`ifdef UART_SEQ_CHECKSUM_EN
                        if (last_byte) begin
                            csum_phase <= 1'b1;
                        end else if (!csum_phase) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            cnt      <= cnt_inc;
                        end
`else
                        if (!last_byte) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            cnt      <= cnt_inc;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_mem_sequencer.md
UART_MEM_SEQUENCER -- requirements
Module: uart_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16: memory address width.
REQ-002 clk_50m  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a transfer when idle.
REQ-005 len  input  ADDR_W  byte count, sampled on accepted start; 0 means 2^ADDR_W.
REQ-006 rx_byte_done  input  1  receiver byte-complete strobe; may stay high for several cycles.
REQ-007 rx_data  input  8  received byte; valid while rx_byte_done is high.
REQ-008 tx_busy  input  1  transmitter busy.
REQ-009 tx_wr_en  output  1  transmitter load strobe.
REQ-010 tx_data  output  8  byte to transmit.
REQ-011 mem_addr  output  ADDR_W  buffer memory address.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_wdata  output  8  memory write data.
REQ-014 mem_rdata  input  8  memory read data; valid one cycle after mem_addr.
REQ-015 proc_start  output  1  one-cycle pulse; starts the downsampling processor.
REQ-016 proc_done  input  1  processor-finished pulse.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at the end of a transfer.

Function
REQ-019 The FSM SHALL have states IDLE, RX, PROC, TX_RD, TX_LOAD, TX_WAIT and DONE.
REQ-020 IDLE->RX SHALL occur on start, latching len and clearing mem_addr to 0; start outside IDLE is ignored.
REQ-021 In RX, each rising edge of rx_byte_done, detected against a 1-cycle-delayed copy, SHALL produce one mem_we pulse of one cycle, with mem_wdata=rx_data, at the current mem_addr.
REQ-022 mem_addr SHALL increment in the cycle after each write.
REQ-023 After the write of byte len-1, the FSM SHALL go RX->PROC, emit proc_start in the first PROC cycle and reset mem_addr to 0.
REQ-024 PROC->TX_RD SHALL occur on proc_done; a proc_done received in any other state is ignored.
REQ-025 TX_RD SHALL present mem_addr for one cycle; TX_LOAD SHALL capture mem_rdata into tx_data.
REQ-026 In TX_LOAD, tx_wr_en SHALL pulse for one cycle only when tx_busy=0; otherwise the FSM holds in TX_LOAD.
REQ-027 TX_WAIT SHALL wait for tx_busy to rise and then fall.
REQ-028 On the fall of tx_busy, the FSM SHALL increment mem_addr and go to TX_RD, or to DONE after byte len-1.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-030 Byte counting SHALL use an ADDR_W+1-bit counter so that len=0 transfers exactly 2^ADDR_W bytes and mem_addr wraps to 0 without an early exit.
REQ-031 rx_byte_done edges outside RX SHALL be dropped, with no memory write.
REQ-032 The strobes mem_we, tx_wr_en, proc_start and done SHALL never be high in the same cycle.

Reset
REQ-033 When rst=1 on a clock edge, the block SHALL enter IDLE and clear mem_addr, mem_we, mem_wdata, tx_wr_en, tx_data, proc_start, busy, done and the internal counters to 0, in any state including mid-transfer.
REQ-034 rst SHALL take priority over start and all other inputs in the same cycle.

Configuration
REQ-035 With UART_SEQ_CHECKSUM_EN defined, the block SHALL keep an 8-bit running XOR of all bytes sent; after byte len-1 it transmits that XOR as one extra byte, using the same TX_LOAD/TX_WAIT handshake, before DONE.
REQ-036 Without UART_SEQ_CHECKSUM_EN, exactly len bytes SHALL be transmitted and no checksum logic is present.

Verification
REQ-037 Reset mid-RX: rst after 2 of 4 bytes -> next cycle busy=0, mem_addr=0, and no further mem_we.
REQ-038 len=3, rx bytes 0xA5,0x3C,0x0F with rx_byte_done held 4 cycles each -> exactly 3 mem_we pulses at addresses 0,1,2, then one proc_start.
REQ-039 proc_done, then memory containing 0x11,0x22,0x33 and a transmitter model busy 10 cycles per byte -> tx_data sequence 0x11,0x22,0x33, then done, with tx_wr_en never high while tx_busy=1.
REQ-040 With UART_SEQ_CHECKSUM_EN and the REQ-039 data -> a fourth byte 0x00 (0x11^0x22^0x33) is sent before done.
REQ-041 ADDR_W=4, len=0 -> 16 writes, addresses 0..15, and mem_addr wraps to 0 at PROC.
REQ-042 start pulsed during TX, and proc_done pulsed during RX -> both ignored; the transfer completes unchanged.
